shift_reg_framer: RTL and testbench

- Parametrised successor to the fixed 32-bit serial-in shift register used at the chip top.
- Shifts serial data at a selectable direction and counts bits into frames of WIDTH bits.
- Captures each complete frame into a shadow register with a valid/ack handshake and overrun detection.
- Presents one selectable 8-bit slice on the 8-bit output pins.

---
 rtl/shift_reg_framer_pkg.sv | 19 +
 rtl/framer_byte_mux.sv | 21 ++
 rtl/shift_reg_framer.sv | 114 +++++++++++
 tb/tb_shift_reg_framer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_framer_pkg.sv
// Shared types and constants for the serial shift-register framer.
package shift_reg_framer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Width of a byte selector for a WIDTH-bit word, never narrower than 1 bit.
    function automatic int calc_sel_w(input int width);
        int n;
        n = width / BYTE_W;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/framer_byte_mux.sv
// Combinational slice select of a wide word onto a narrow output; out-of-range selects give 0.
module framer_byte_mux #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8,
    parameter int SEL_W = 2
) (
    input  logic [IN_W-1:0]  word,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] slice
);

    localparam int N = IN_W / OUT_W;

    always_comb begin
        slice = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) slice = word[i*OUT_W +: OUT_W];
        end
    end

endmodule

// File: rtl/shift_reg_framer.sv
// Serial-in framer: shifts bits into WIDTH-bit frames and hands them off via a shadow register.
// Optional trailing even-parity bit per frame when SHIFT_REG_FRAMER_PARITY_EN is defined.
module shift_reg_framer
    import shift_reg_framer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1),
    parameter int SEL_W = calc_sel_w(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_in,
    input  logic              en,
    input  logic              dir,
    input  logic              clr,
    input  logic              word_ack,
    input  logic [SEL_W-1:0]  byte_sel,
    output logic [BYTE_W-1:0] data_out,
    output logic [WIDTH-1:0]  word_out,
    output logic              word_valid,
    output logic              overrun,
`ifdef SHIFT_REG_FRAMER_PARITY_EN
    output logic              parity_err,
`endif
    output logic              busy
);

`ifdef SHIFT_REG_FRAMER_PARITY_EN
    localparam state_t DONE_ST = PARITY;
`else
    localparam state_t DONE_ST = IDLE;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] sreg, shadow, shift_val, frame;
    logic             do_shift, last_bit, commit;

    always_comb begin
        shift_val = dir ? {data_in, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], data_in};
        do_shift  = en && !clr && (state != PARITY);
        last_bit  = do_shift && (cnt == CNT_W'(WIDTH - 1));
`ifdef SHIFT_REG_FRAMER_PARITY_EN
        // Frame already sits in sreg; this cycle's data_in is the parity bit.
        commit    = en && !clr && (state == PARITY);
        frame     = sreg;
`else
        commit    = last_bit;
        frame     = shift_val;
`endif
        state_nxt = state;
        cnt_nxt   = cnt;
        if (clr) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (do_shift) begin
            if (last_bit) begin
                state_nxt = DONE_ST;
                cnt_nxt   = '0;
            end else begin
                state_nxt = SHIFT;
                cnt_nxt   = cnt + 1'b1;
            end
        end else if (commit) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            shadow     <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef SHIFT_REG_FRAMER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (do_shift) sreg <= shift_val;
            // An ack in the completion cycle frees the shadow for the new frame.
            if (commit) begin
                if (word_valid && !word_ack) begin
                    overrun <= 1'b1;
                end else begin
                    shadow     <= frame;
                    word_valid <= 1'b1;
                end
            end else if (word_ack) begin
                word_valid <= 1'b0;
            end
`ifdef SHIFT_REG_FRAMER_PARITY_EN
            if (commit) parity_err <= (^sreg) ^ data_in;
`endif
        end
    end

    assign word_out = shadow;
    assign busy     = (state == SHIFT) || (state == PARITY);

    framer_byte_mux #(
        .IN_W (WIDTH),
        .OUT_W(BYTE_W),
        .SEL_W(SEL_W)
    ) u_byte_mux (
        .word (shadow),
        .sel  (byte_sel),
        .slice(data_out)
    );

endmodule

// File: tb/tb_shift_reg_framer.sv
// Scoreboard bench for shift_reg_framer (WIDTH=32 main instance, WIDTH=24 for out-of-range byte select).
module tb_shift_reg_framer;

    logic        clk = 1'b0;
    logic        reset, data_in, en, dir, clr, word_ack;
    logic [1:0]  byte_sel, byte_sel24;
    logic [7:0]  data_out, data_out24;
    logic [31:0] word_out;
    logic [23:0] word_out24;
    logic        word_valid, overrun, busy;
    logic        word_valid24, overrun24, busy24;
`ifdef SHIFT_REG_FRAMER_PARITY_EN
    logic        parity_err, parity_err24;
`endif

    typedef struct {
        logic [31:0] w;
        int          c;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic        wv_q = 1'b0;
    logic [31:0] wo_q = '0;

    shift_reg_framer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .en(en), .dir(dir), .clr(clr),
        .word_ack(word_ack), .byte_sel(byte_sel), .data_out(data_out), .word_out(word_out),
        .word_valid(word_valid), .overrun(overrun),
`ifdef SHIFT_REG_FRAMER_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy(busy)
    );

    shift_reg_framer #(.WIDTH(24)) dut24 (
        .clk(clk), .reset(reset), .data_in(data_in), .en(en), .dir(dir), .clr(clr),
        .word_ack(1'b0), .byte_sel(byte_sel24), .data_out(data_out24), .word_out(word_out24),
        .word_valid(word_valid24), .overrun(overrun24),
`ifdef SHIFT_REG_FRAMER_PARITY_EN
        .parity_err(parity_err24),
`endif
        .busy(busy24)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // A new frame is visible when word_valid rises or the shadow reloads under an ack.
    always @(negedge clk) begin
        if (!reset && word_valid && (!wv_q || word_out != wo_q)) begin
            if (sb_q.size() == 0) begin
                chk("sb_extra", 32'd1, 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                chk("sb_word", word_out, sb_e.w);
                chk("sb_lat", cyc, sb_e.c);
            end
        end
        wv_q = word_valid;
        wo_q = word_out;
    end

    task automatic send(input logic [31:0] w, input logic d, input bit gap,
                        input bit ack_last, input bit bad_par, input bit push);
        exp_t e;
        dir = d;
        for (int i = 0; i < 32; i++) begin
            data_in  = d ? w[i] : w[31-i];
            en       = 1'b1;
`ifdef SHIFT_REG_FRAMER_PARITY_EN
            word_ack = 1'b0;
`else
            word_ack = ack_last && (i == 31);
`endif
            @(posedge clk); #1;
            if (gap && i < 31) begin
                en = 1'b0;
                word_ack = 1'b0;
                @(posedge clk); #1;
            end
        end
`ifdef SHIFT_REG_FRAMER_PARITY_EN
        data_in  = (^w) ^ bad_par;
        en       = 1'b1;
        word_ack = ack_last;
        @(posedge clk); #1;
`else
        if (bad_par) data_in = 1'b0;
`endif
        en       = 1'b0;
        word_ack = 1'b0;
        if (push) begin
            e.w = w;
            e.c = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic ack_word();
        word_ack = 1'b1;
        @(posedge clk); #1;
        word_ack = 1'b0;
        chk("ack_clr", {31'd0, word_valid}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        reset = 1'b1; data_in = 0; en = 0; dir = 0; clr = 0; word_ack = 0;
        byte_sel = 0; byte_sel24 = 0;
        @(posedge clk); #1;
        chk("rst_word", word_out, 32'd0);
        chk("rst_valid", {31'd0, word_valid}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dout", {24'd0, data_out}, 32'd0);
        reset = 1'b0;

        // Reset mid-frame, then a clean MSB-first frame.
        for (int i = 0; i < 13; i++) begin
            data_in = 1'($urandom); en = 1'b1;
            @(posedge clk); #1;
        end
        en = 1'b0;
        chk("busy_mid", {31'd0, busy}, 32'd1);
        reset = 1'b1; #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_valid", {31'd0, word_valid}, 32'd0);
        chk("arst_word", word_out, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        w = 32'hA5C3_1E7F;
        send(w, 1'b0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            byte_sel = 2'(i); #1;
            chk("byte_sel", {24'd0, data_out}, {24'd0, w[8*i +: 8]});
        end
        chk("w24_word", {8'd0, word_out24}, 32'h00A5_C31E);
        byte_sel24 = 2'd0; #1; chk("w24_b0", {24'd0, data_out24}, 32'h1E);
        byte_sel24 = 2'd2; #1; chk("w24_b2", {24'd0, data_out24}, 32'hA5);
        byte_sel24 = 2'd3; #1; chk("w24_oor", {24'd0, data_out24}, 32'h00);
        ack_word();

        // LSB-first, continuous then with en gaps.
        send(w, 1'b1, 0, 0, 0, 1);
        ack_word();
        send(w, 1'b1, 1, 0, 0, 1);
        ack_word();

        // Back-to-back without ack: overrun, first word kept.
        send(32'h0F0F_1234, 1'b0, 0, 0, 0, 1);
        send(32'h89AB_CDEF, 1'b0, 0, 0, 0, 0);
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        chk("ovr_keep", word_out, 32'h0F0F_1234);
        ack_word();
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Ack in the completion cycle wins.
        do_reset();
        send(32'h1111_2222, 1'b0, 0, 0, 0, 1);
        send(32'h3333_4444, 1'b1, 0, 1, 0, 1);
        chk("ackwin_ovr", {31'd0, overrun}, 32'd0);
        chk("ackwin_valid", {31'd0, word_valid}, 32'd1);
        chk("ackwin_word", word_out, 32'h3333_4444);
        ack_word();

        // clr with en high after 20 bits aborts the frame.
        for (int i = 0; i < 20; i++) begin
            data_in = 1'($urandom); en = 1'b1;
            @(posedge clk); #1;
        end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; en = 1'b0;
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_valid", {31'd0, word_valid}, 32'd0);
        send(32'hDEAD_BEEF, 1'b0, 0, 0, 0, 1);
        ack_word();

`ifdef SHIFT_REG_FRAMER_PARITY_EN
        send(32'h0000_0001, 1'b0, 0, 0, 0, 1);
        chk("par_ok", {31'd0, parity_err}, 32'd0);
        ack_word();
        send(32'h0000_0001, 1'b0, 0, 0, 1, 1);
        chk("par_err", {31'd0, parity_err}, 32'd1);
        ack_word();
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
